// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, W x W -> 2W bits, unsigned or two's-complement.
// The multiplier takes operand magnitudes, accumulates one partial product per cycle
// for W cycles, and then applies the product sign in a single finishing cycle.
// One operation runs at a time. A result appears W+1 cycles after start is accepted.
module seq_mult #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e           state_q;
  logic [W-1:0]     xm_q;
  logic [W-1:0]     ym_q;
  logic [2*W-1:0]   acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_q;

  logic [W-1:0]     x_mag;
  logic [W-1:0]     y_mag;
  logic [2*W-1:0]   pp;
  logic [2*W-1:0]   acc_nxt;
  logic             last_iter;

  // Operand magnitudes and the next accumulator value for the current iteration.
  // Negating the most negative value gives 2^(W-1), which still fits as a W-bit unsigned number.
  always_comb begin
    x_mag     = (signed_mode && x[W-1]) ? -x : x;
    y_mag     = (signed_mode && y[W-1]) ? -y : y;
    pp        = {{W{1'b0}}, xm_q} << cnt_q;
    acc_nxt   = ym_q[cnt_q] ? (acc_q + pp) : acc_q;
    last_iter = (cnt_q == CntW'(W - 1));
  end

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      xm_q    <= '0;
      ym_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            xm_q    <= x_mag;
            ym_q    <= y_mag;
            neg_q   <= signed_mode & (x[W-1] ^ y[W-1]);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_nxt;
          if (last_iter) begin
            state_q <= StFin;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFin: begin
          p       <= neg_q ? -acc_q : acc_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at W=4, 8 and 16. Each issued operation pushes its
// expected product and accept cycle; a negedge monitor pops on done and checks value,
// latency, busy and that p holds between results.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: W=4, instance 1: W=8, instance 2: W=16.
  logic        start4, sm4, busy4, done4;
  logic [3:0]  x4, y4;
  logic [7:0]  p4;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] x16, y16;
  logic [31:0] p16;

  seq_mult #(.W(4)) u_m4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .p(p4)
  );
  seq_mult #(.W(8)) u_m8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .p(p8)
  );
  seq_mult #(.W(16)) u_m16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .x(x16), .y(y16),
    .busy(busy16), .done(done16), .p(p16)
  );

  typedef struct {
    logic [63:0] exp;
    int          cyc;
    int          w;
  } ent_t;

  ent_t        sb[3][$];
  logic [63:0] lp[3];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          armed = 1'b0;

  function automatic int wid(int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : 16;
  endfunction

  // Exact product of two w-bit operands, truncated to 2w bits.
  function automatic logic [63:0] ref_prod(int w, logic sm, logic [31:0] a, logic [31:0] b);
    longint      ua, ub, av, bv, pr;
    logic [63:0] m;
    ua = longint'({32'b0, a}) & ((64'sd1 <<< w) - 1);
    ub = longint'({32'b0, b}) & ((64'sd1 <<< w) - 1);
    av = (sm && ua[w-1]) ? ua - (64'sd1 <<< w) : ua;
    bv = (sm && ub[w-1]) ? ub - (64'sd1 <<< w) : ub;
    pr = av * bv;
    m  = (2 * w >= 64) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return 64'(pr) & m;
  endfunction

  task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (W=%0d) at cycle %0d: got %0h, want %0h", name, wid(i), cyc, act, exp);
    end
  endtask

  task automatic mon(int i, logic d, logic b, logic [63:0] pv);
    ent_t e;
    if (d === 1'b1) begin
      if (sb[i].size() == 0) begin
        chk("spurious_done", i, 64'd1, 64'd0);
      end else begin
        e = sb[i].pop_front();
        lp[i] = e.exp;
        chk("latency", i, 64'(cyc - e.cyc), 64'(e.w + 1));
      end
    end else if (d !== 1'b0) begin
      chk("done_known", i, 64'(d), 64'd0);
    end
    chk(d === 1'b1 ? "product" : "p_hold", i, pv, lp[i]);
    chk("busy", i, 64'(b), 64'(sb[i].size() != 0));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      mon(0, done4, busy4, {56'b0, p4});
      mon(1, done8, busy8, {48'b0, p8});
      mon(2, done16, busy16, {32'b0, p16});
    end
  end

  task automatic drive(int i, logic st, logic sm, logic [31:0] a, logic [31:0] b);
    case (i)
      0: begin start4 = st; sm4 = sm; x4 = a[3:0]; y4 = b[3:0]; end
      1: begin start8 = st; sm8 = sm; x8 = a[7:0]; y8 = b[7:0]; end
      default: begin start16 = st; sm16 = sm; x16 = a[15:0]; y16 = b[15:0]; end
    endcase
  endtask

  function automatic logic get_done(int i);
    return (i == 0) ? done4 : (i == 1) ? done8 : done16;
  endfunction

  // Present start for one edge, record the expectation, scramble the inputs,
  // then wait (bounded) for the done cycle so the next call issues back-to-back.
  task automatic accept(int i, logic sm, logic [31:0] a, logic [31:0] b);
    ent_t e;
    drive(i, 1'b1, sm, a, b);
    @(posedge clk);
    #1;
    e.exp = ref_prod(wid(i), sm, a, b);
    e.cyc = cyc;
    e.w   = wid(i);
    sb[i].push_back(e);
    drive(i, 1'b0, logic'($urandom), $urandom, $urandom);
  endtask

  task automatic wait_done(int i);
    for (int t = 0; t < 40; t++) begin
      if (get_done(i) === 1'b1) return;
      @(posedge clk);
      #1;
    end
    chk("done_timeout", i, 64'd0, 64'd1);
  endtask

  task automatic run(int i, logic sm, logic [31:0] a, logic [31:0] b);
    accept(i, sm, a, b);
    wait_done(i);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, 1'b0, 32'd0, 32'd0);
      lp[i] = 64'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // W=8 unsigned corner, then idle hold.
    run(1, 1'b0, 32'd255, 32'd255);
    repeat (5) @(posedge clk);
    #1;

    // W=8 signed, second operation issued in the done cycle.
    run(1, 1'b1, 32'h80, 32'h80);
    run(1, 1'b1, 32'hFD, 32'h05);
    repeat (3) @(posedge clk);
    #1;

    // Start re-asserted during CALC must be ignored.
    accept(1, 1'b0, 32'd12, 32'd10);
    drive(1, 1'b1, 1'b0, 32'd1, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_done(1);
    repeat (12) @(posedge clk);
    #1;

    // Reset in CALC iteration 4 discards the operation.
    accept(1, 1'b0, 32'd200, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb[1].delete();
    for (int i = 0; i < 3; i++) lp[i] = 64'd0;
    repeat (15) @(posedge clk);
    #1;
    run(1, 1'b0, 32'd7, 32'd6);

    // W=4 exhaustive, both modes, back-to-back.
    for (int sm = 0; sm < 2; sm++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run(0, logic'(sm), 32'(a), 32'(b));

    // W=16 smoke.
    run(2, 1'b0, 32'hFFFF, 32'hFFFF);
    run(2, 1'b1, 32'h8000, 32'h7FFF);

    // Randomized operations.
    for (int n = 0; n < 100; n++) begin
      run(1, logic'($urandom), $urandom, $urandom);
      run(2, logic'($urandom), $urandom, $urandom);
    end

    repeat (25) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("drained", i, 64'(sb[i].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
